// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one input beat stream fanned out to NCH
// registered output channels, each with its own valid/ready pair.
interface demux_stream_if #(
  parameter int DW  = 16,
  parameter int NCH = 8
);
  localparam int SW = $clog2(NCH);

  logic              din_valid;
  logic              din_ready;
  logic [DW-1:0]     din;
  logic [SW-1:0]     din_sel;
  logic              din_bcast;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    dout_valid;
  logic [NCH-1:0]    dout_ready;

  modport master (
    output din_valid, din, din_sel, din_bcast, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din_valid, din, din_sel, din_bcast, dout_ready,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-NCH stream demultiplexer with per-channel one-entry slots,
// all-or-nothing broadcast and a saturating counter of out-of-range drops.
module demux_stream #(
  parameter int DW  = 16,
  parameter int NCH = 8,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  demux_stream_if.slave stream,
  output logic [CW-1:0] drop_cnt
);
  localparam int SW = $clog2(NCH);

  logic [NCH-1:0] vld_q;
  logic [DW-1:0]  data_q [NCH];

  logic [NCH-1:0] slot_free;
  logic [NCH-1:0] sel_hit;
  logic [NCH-1:0] load;
  logic           in_range;
  logic           sel_free;
  logic           accept;
  logic           drop;

  // A select decode with no hit is exactly the out-of-range case, so no
  // magnitude compare against NCH is needed for non-power-of-two widths.
  always_comb begin
    slot_free = '0;
    sel_hit   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      slot_free[k] = !vld_q[k] | stream.dout_ready[k];
      sel_hit[k]   = (stream.din_sel == SW'(k));
    end
  end

  assign in_range = |sel_hit;
  assign sel_free = |(slot_free & sel_hit);

  always_comb begin
    stream.din_ready = 1'b0;
    if (rst)
      stream.din_ready = 1'b0;
    else if (stream.din_bcast)
      stream.din_ready = &slot_free;
    else if (in_range)
      stream.din_ready = sel_free;
    else
      stream.din_ready = 1'b1;
  end

  assign accept = stream.din_valid & stream.din_ready;
  assign drop   = accept & !stream.din_bcast & !in_range;

  always_comb begin
    load = '0;
    if (accept)
      load = stream.din_bcast ? '1 : sel_hit;
  end

  assign stream.dout_valid = vld_q;

  always_comb begin
    stream.dout = '0;
    for (int unsigned k = 0; k < NCH; k++)
      stream.dout[k*DW +: DW] = data_q[k];
  end

  // Load takes priority over drain so a full-rate stream has no bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      drop_cnt <= '0;
      for (int unsigned k = 0; k < NCH; k++)
        data_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (load[k]) begin
          data_q[k] <= stream.din;
          vld_q[k]  <= 1'b1;
        end else if (stream.dout_ready[k]) begin
          vld_q[k]  <= 1'b0;
        end
      end
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: per-channel expected-data queues driven
// by a reference ready model, plus directed scenarios and NCH=6 drop checks.
module tb_demux_stream;
  logic clk;
  logic rst;
  logic [7:0] drop_m;
  logic [7:0] drop_b;
  logic [1:0] drop_c;

  int n_checks = 0;
  int n_fail   = 0;

  demux_stream_if #(.DW(16), .NCH(8)) m ();
  demux_stream_if #(.DW(16), .NCH(6)) b ();
  demux_stream_if #(.DW(16), .NCH(6)) c ();

  demux_stream #(.DW(16), .NCH(8), .CW(8)) dut_m (
    .clk(clk), .rst(rst), .stream(m), .drop_cnt(drop_m)
  );
  demux_stream #(.DW(16), .NCH(6), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .stream(b), .drop_cnt(drop_b)
  );
  demux_stream #(.DW(16), .NCH(6), .CW(2)) dut_c (
    .clk(clk), .rst(rst), .stream(c), .drop_cnt(drop_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic six(input logic v, input logic [2:0] s);
    b.din_valid = v; b.din_sel = s;
    c.din_valid = v; c.din_sel = s;
  endtask

  // Reference model: each channel's queue holds what it should present; a
  // non-empty queue means the slot is full.
  logic [15:0] exp_q [8][$];
  logic        exp_rdy;
  logic        free_k;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_din_ready", 64'(m.din_ready), 64'(0));
      for (int k = 0; k < 8; k++) exp_q[k].delete();
    end else begin
      for (int k = 0; k < 8; k++) begin
        check("dout_valid", 64'(m.dout_valid[k]), 64'(exp_q[k].size() != 0));
        if (exp_q[k].size() != 0)
          check("dout_data", 64'(m.dout[k*16 +: 16]), 64'(exp_q[k][0]));
      end
      if (m.din_bcast) begin
        exp_rdy = 1'b1;
        for (int k = 0; k < 8; k++)
          if (exp_q[k].size() != 0 && !m.dout_ready[k]) exp_rdy = 1'b0;
      end else begin
        free_k  = (exp_q[m.din_sel].size() == 0) || m.dout_ready[m.din_sel];
        exp_rdy = free_k;
      end
      check("din_ready", 64'(m.din_ready), 64'(exp_rdy));
      for (int k = 0; k < 8; k++)
        if (exp_q[k].size() != 0 && m.dout_ready[k]) void'(exp_q[k].pop_front());
      if (m.din_valid && exp_rdy) begin
        for (int k = 0; k < 8; k++)
          if (m.din_bcast || (m.din_sel == 3'(k))) exp_q[k].push_back(m.din);
      end
      check("drop_cnt_main", 64'(drop_m), 64'(0));
    end
  end

  initial begin
    int total;
    logic [2:0] sels [4];
    sels[0] = 3'd7; sels[1] = 3'd7; sels[2] = 3'd7; sels[3] = 3'd6;

    rst = 1'b1;
    m.din_valid = 1'b0; m.din = '0; m.din_sel = '0; m.din_bcast = 1'b0; m.dout_ready = '1;
    b.din = '0; b.din_bcast = 1'b0; b.dout_ready = '1;
    c.din = '0; c.din_bcast = 1'b0; c.dout_ready = '1;
    six(1'b0, 3'd0);
    repeat (3) step();
    check("reset_valid", 64'(m.dout_valid), 64'(0));
    check("reset_dout_zero", 64'(|m.dout), 64'(0));
    check("reset_drop", 64'(drop_m), 64'(0));
    rst = 1'b0;

    // Out-of-range drops on NCH=6, once wide counter and once 2-bit counter.
    for (int i = 0; i < 4; i++) begin
      six(1'b1, sels[i]);
      #1;
      check("drop_ready", 64'(b.din_ready), 64'(1));
      step();
      if (i == 2) check("drop_c_after3", 64'(drop_c), 64'(3));
    end
    six(1'b0, 3'd0);
    #1;
    check("drop_b_cnt", 64'(drop_b), 64'(4));
    check("drop_c_sat", 64'(drop_c), 64'(3));
    check("drop_b_novalid", 64'(b.dout_valid), 64'(0));
    check("drop_c_novalid", 64'(c.dout_valid), 64'(0));
    six(1'b1, 3'd7);
    step();
    six(1'b0, 3'd0);
    check("drop_b_cnt5", 64'(drop_b), 64'(5));
    check("drop_c_sat5", 64'(drop_c), 64'(3));

    // Unicast, 1-cycle latency.
    m.din = 16'hA5A5; m.din_sel = 3'd3; m.din_valid = 1'b1;
    step();
    m.din_valid = 1'b0;
    check("uni_valid", 64'(m.dout_valid), 64'(8'h08));
    check("uni_data", 64'(m.dout[3*16 +: 16]), 64'(16'hA5A5));
    step();
    check("uni_drained", 64'(m.dout_valid), 64'(0));

    // Backpressure on channel 2.
    m.dout_ready[2] = 1'b0;
    m.din = 16'h0001; m.din_sel = 3'd2; m.din_valid = 1'b1;
    step();
    m.din = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready_low", 64'(m.din_ready), 64'(0));
      check("bp_hold", 64'(m.dout[2*16 +: 16]), 64'(16'h0001));
      step();
    end
    m.dout_ready[2] = 1'b1;
    #1;
    check("bp_ready_high", 64'(m.din_ready), 64'(1));
    step();
    m.din_valid = 1'b0;
    check("bp_next", 64'(m.dout[2*16 +: 16]), 64'(16'h0002));
    check("bp_next_valid", 64'(m.dout_valid[2]), 64'(1));
    step();

    // Broadcast blocked by a full, stalled channel 5.
    m.dout_ready[5] = 1'b0;
    m.din = 16'h1234; m.din_sel = 3'd5; m.din_valid = 1'b1;
    step();
    m.din = 16'hBEEF; m.din_bcast = 1'b1;
    #1;
    check("bc_blocked", 64'(m.din_ready), 64'(0));
    step();
    step();
    check("bc_no_load", 64'(m.dout_valid), 64'(8'h20));
    m.dout_ready[5] = 1'b1;
    #1;
    check("bc_ready", 64'(m.din_ready), 64'(1));
    step();
    m.din_valid = 1'b0; m.din_bcast = 1'b0;
    check("bc_all_valid", 64'(m.dout_valid), 64'(8'hFF));
    for (int k = 0; k < 8; k++)
      check("bc_data", 64'(m.dout[k*16 +: 16]), 64'(16'hBEEF));
    step();

    // 100 back-to-back beats to channel 0.
    m.din_sel = 3'd0; m.din_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      m.din = 16'(16'h1000 + i);
      step();
      check("b2b_valid", 64'(m.dout_valid[0]), 64'(1));
      check("b2b_data", 64'(m.dout[15:0]), 64'(16'h1000 + i));
    end
    m.din_valid = 1'b0;
    step();
    check("b2b_end", 64'(m.dout_valid[0]), 64'(0));

    // Random traffic, checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      m.din        = 16'($urandom);
      m.din_sel    = 3'($urandom_range(0, 7));
      m.din_bcast  = ($urandom_range(0, 7) == 0);
      m.din_valid  = ($urandom_range(0, 3) != 0);
      m.dout_ready = 8'($urandom);
      step();
    end
    m.din_valid = 1'b0; m.din_bcast = 1'b0; m.dout_ready = '1;
    repeat (2) step();

    // Reset with held beats and a beat on the input.
    m.dout_ready[1] = 1'b0; m.dout_ready[4] = 1'b0;
    m.din = 16'h1111; m.din_sel = 3'd1; m.din_valid = 1'b1;
    step();
    m.din = 16'h4444; m.din_sel = 3'd4;
    step();
    check("pre_rst_valid", 64'(m.dout_valid), 64'(8'h12));
    rst = 1'b1; m.din = 16'h6666; m.din_sel = 3'd6;
    #1;
    check("rst_no_accept", 64'(m.din_ready), 64'(0));
    step();
    rst = 1'b0; m.din_valid = 1'b0;
    check("rst_valid", 64'(m.dout_valid), 64'(0));
    check("rst_dout", 64'(|m.dout), 64'(0));
    check("rst_drop", 64'(drop_m), 64'(0));
    m.dout_ready = '1;
    repeat (3) step();

    total = 0;
    for (int k = 0; k < 8; k++) total += exp_q[k].size();
    check("sb_empty", 64'(total), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
